// File: rtl/pc_redirect_sched_pkg.sv
// Shared definitions for the PC redirect scheduler: controller state encoding,
// PC width and reset level.
package pc_redirect_sched_pkg;

    // Core-wide PC bus width
    localparam int YSYX22040228_PCBUS = 64;

    localparam int MAX_OUT_DEF = 2;
    localparam int CNT_W_DEF   = 32;

    // Reset is asserted when rst is low
    localparam logic RST_ACTIVE = 1'b0;

    typedef enum logic [1:0] {
        ST_BOOT  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_REDIR = 2'd3
    } state_e;

endpackage

// File: rtl/pc_redirect_sched_sat_updown_cnt.sv
// Up/down counter clamped to [0, MAX]. A simultaneous up and down step cancels.
module pc_redirect_sched_sat_updown_cnt
    import pc_redirect_sched_pkg::*;
#(
    parameter int W   = 2,
    parameter int MAX = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc_i,
    input  logic         dec_i,
    output logic [W-1:0] cnt_o
);

    localparam logic [W-1:0] MAX_V = W'(MAX);
    localparam logic [W-1:0] ONE_V = W'(1);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Next count: step up or down, never leaving the [0, MAX] range
    always_comb begin
        cnt_d = cnt_q;
        if (inc_i && !dec_i && (cnt_q != MAX_V)) begin
            cnt_d = cnt_q + ONE_V;
        end else if (dec_i && !inc_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - ONE_V;
        end
    end

    // Count register
    always_ff @(posedge clk or negedge rst) begin
        if (rst == RST_ACTIVE) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/pc_redirect_sched.sv
// Front-end PC controller: issues fetch requests, tracks outstanding fetches,
// arbitrates EX/ID redirects, kills wrong-path responses and drives the pc
// register's stall/redirect controls.
module pc_redirect_sched
    import pc_redirect_sched_pkg::*;
#(
    parameter int PC_W    = YSYX22040228_PCBUS,
    parameter int MAX_OUT = MAX_OUT_DEF,
    parameter int CNT_W   = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ex_redir_valid_i,
    input  logic [PC_W-1:0]  ex_redir_pc_i,
    input  logic             id_redir_valid_i,
    input  logic [PC_W-1:0]  id_redir_pc_i,
    input  logic             hz_stall_i,
    input  logic             if_req_ready_i,
    input  logic             if_resp_valid_i,
    output logic             if_req_valid_o,
    output logic             if_resp_kill_o,
    output logic             pc_stall_o,
    output logic             pc_redir_ena_o,
    output logic [PC_W-1:0]  pc_redir_pc_o,
    output logic             flush_ifid_o,
    output logic             flush_idex_o,
    output logic [CNT_W-1:0] redir_cnt_o
);

    localparam int               OC_W    = $clog2(MAX_OUT + 1);
    localparam logic [OC_W-1:0]  MAX_CNT = OC_W'(MAX_OUT);
    localparam logic [OC_W-1:0]  OC_ONE  = OC_W'(1);
    localparam logic [CNT_W-1:0] RC_ONE  = CNT_W'(1);

    state_e           state_q, state_d;
    logic [OC_W-1:0]  out_cnt;
    logic [OC_W-1:0]  kill_cnt_q, kill_cnt_d;
    logic [OC_W-1:0]  kill_left;
    logic [PC_W-1:0]  pend_pc_q, pend_pc_d;
    logic [CNT_W-1:0] redir_cnt_q, redir_cnt_d;
    logic             accept;
    logic             resp_eff;

    // A response with nothing outstanding is a protocol error and is ignored
    assign resp_eff = if_resp_valid_i && (out_cnt != '0);

    pc_redirect_sched_sat_updown_cnt #(
        .W   (OC_W),
        .MAX (MAX_OUT)
    ) u_out_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc_i (accept),
        .dec_i (resp_eff),
        .cnt_o (out_cnt)
    );

    // Next-state and output decode; everything defaults to the "hold pc" view
    always_comb begin
        state_d        = state_q;
        kill_cnt_d     = kill_cnt_q;
        pend_pc_d      = pend_pc_q;
        redir_cnt_d    = redir_cnt_q;
        kill_left      = '0;
        accept         = 1'b0;
        if_req_valid_o = 1'b0;
        if_resp_kill_o = 1'b0;
        pc_stall_o     = 1'b1;
        pc_redir_ena_o = 1'b0;
        pc_redir_pc_o  = '0;
        flush_ifid_o   = 1'b0;
        flush_idex_o   = 1'b0;

        case (state_q)
            ST_BOOT: begin
                state_d = ST_RUN;
            end

            ST_RUN: begin
                if (ex_redir_valid_i || id_redir_valid_i) begin
                    // EX is older in program order, so it wins over ID
                    flush_ifid_o = 1'b1;
                    flush_idex_o = ex_redir_valid_i;
                    pend_pc_d    = ex_redir_valid_i ? ex_redir_pc_i : id_redir_pc_i;
                    // Fetches still in flight after this cycle are wrong-path
                    kill_left    = out_cnt - OC_W'(resp_eff);
                    kill_cnt_d   = kill_left;
                    state_d      = (kill_left == '0) ? ST_REDIR : ST_DRAIN;
                end else begin
                    if_req_valid_o = !hz_stall_i && (out_cnt < MAX_CNT);
                    accept         = if_req_valid_o && if_req_ready_i;
                    pc_stall_o     = !accept;
                end
            end

            ST_DRAIN: begin
                // ID has already been flushed, so only a newer EX redirect matters
                if (ex_redir_valid_i) begin
                    flush_ifid_o = 1'b1;
                    flush_idex_o = 1'b1;
                    pend_pc_d    = ex_redir_pc_i;
                end
                if (resp_eff) begin
                    if_resp_kill_o = 1'b1;
                    kill_cnt_d     = kill_cnt_q - OC_ONE;
                    if (kill_cnt_q == OC_ONE) begin
                        state_d = ST_REDIR;
                    end
                end
            end

            ST_REDIR: begin
                pc_redir_ena_o = 1'b1;
                pc_stall_o     = 1'b0;
                // A same-cycle EX redirect is newer than the pending target
                if (ex_redir_valid_i) begin
                    pc_redir_pc_o = ex_redir_pc_i;
                    flush_ifid_o  = 1'b1;
                    flush_idex_o  = 1'b1;
                end else begin
                    pc_redir_pc_o = pend_pc_q;
                end
                if (redir_cnt_q != '1) begin
                    redir_cnt_d = redir_cnt_q + RC_ONE;
                end
                state_d = ST_RUN;
            end

            default: begin
                state_d = ST_BOOT;
            end
        endcase
    end

    // Controller state registers
    always_ff @(posedge clk or negedge rst) begin
        if (rst == RST_ACTIVE) begin
            state_q     <= ST_BOOT;
            kill_cnt_q  <= '0;
            pend_pc_q   <= '0;
            redir_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            kill_cnt_q  <= kill_cnt_d;
            pend_pc_q   <= pend_pc_d;
            redir_cnt_q <= redir_cnt_d;
        end
    end

    assign redir_cnt_o = redir_cnt_q;

endmodule
